// File: rtl/hash_bank_conflict_scheduler.sv
// Bank conflict scheduler: serializes 16 lane requests onto 16 banks,
// one lane per bank per beat, dropping what remains after MAX_ROUNDS.
module hash_bank_conflict_scheduler #(
   parameter int MAX_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_req,
   input  logic [63:0] in_bank,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [79:0] bank_sel,
   output logic [15:0] grant_mask,
   output logic        out_last,
   output logic [15:0] drop_mask
);

   typedef enum logic {IDLE, SERVE} state_t;

   localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pending;
   logic [15:0] w_pending_nxt;
   logic [63:0] r_bank_q;
   logic [63:0] w_bank_nxt;
   logic [3:0]  r_round;
   logic [3:0]  w_round_nxt;
   logic [15:0] w_left;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_bank_q  <= '0;
         r_round   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_bank_q  <= w_bank_nxt;
         r_round   <= w_round_nxt;
      end
   end

   // Descending scan so the lowest matching lane wins each bank.
   always_comb begin
      bank_sel   = {16{5'd16}};
      grant_mask = '0;
      if (r_state == SERVE) begin
         for (int b = 0; b < 16; b++) begin
            for (int l = 15; l >= 0; l--) begin
               if (r_pending[l] && (r_bank_q[4*l +: 4] == 4'(b)))
                  bank_sel[5*b +: 5] = 5'(l);
            end
         end
         for (int l = 0; l < 16; l++) begin
            if (r_pending[l] &&
                (bank_sel[5*r_bank_q[4*l +: 4] +: 5] == 5'(l)))
               grant_mask[l] = 1'b1;
         end
      end
   end

   always_comb begin
      w_left    = r_pending & ~grant_mask;
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == SERVE);
      out_last  = (r_state == SERVE) &&
                  ((w_left == '0) || (r_round == LAST_ROUND));
      drop_mask = out_last ? w_left : '0;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_bank_nxt    = r_bank_q;
      w_round_nxt   = r_round;
      unique case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_pending_nxt = in_req;
               w_bank_nxt    = in_bank;
               w_round_nxt   = '0;
               w_state_nxt   = SERVE;
            end
         end
         SERVE: begin
            if (out_ready) begin
               w_pending_nxt = w_left;
               w_round_nxt   = r_round + 4'd1;
               if (out_last) begin
                  w_pending_nxt = '0;
                  w_state_nxt   = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule
